display_timing_param: RTL and testbench

Parameterised display timing generator that drives the pixel-clock domain of every graphics top. It produces screen coordinates, sync pulses, data-enable, line/frame strobes and a frame counter. Its outputs feed directly into the paint logic of the top, which colours pixels from `sx`/`sy` and gates them with `de`. Defaults give 640x480 at 60 Hz from a 25.2 MHz `clk_pix`.

---
 rtl/display_timing_param.sv | 108 ++++++++++
 tb/tb_display_timing_param.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_timing_param.sv
// ============================================================================
// Module   : display_timing_param
// Brief    : Parameterised raster timing generator: coordinates, syncs, DE,
//            line/frame strobes and frame counter in the clk_pix domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_timing_param #(
  parameter int CORDW  = 10,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [15:0]      frame_cnt
);

  localparam int c_h_total = H_RES + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] c_h_last = CORDW'(c_h_total - 1);
  localparam logic [CORDW-1:0] c_v_last = CORDW'(c_v_total - 1);
  localparam logic [CORDW-1:0] c_h_res  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] c_v_res  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] c_hs_sta = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] c_hs_end = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] c_vs_sta = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] c_vs_end = CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [CORDW-1:0] c_one    = CORDW'(1);

  logic [CORDW-1:0] r_sx;
  logic [CORDW-1:0] r_sy;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_de;
  logic             r_line;
  logic             r_frame;
  logic [15:0]      r_frame_cnt;

  logic [CORDW-1:0] w_sx_next;
  logic [CORDW-1:0] w_sy_next;
  logic             w_line_next;
  logic             w_frame_next;

  always_comb begin
    w_sx_next = r_sx + c_one;
    w_sy_next = r_sy;
    if (r_sx == c_h_last) begin
      w_sx_next = '0;
      w_sy_next = (r_sy == c_v_last) ? '0 : r_sy + c_one;
    end
    w_line_next  = (w_sx_next == '0);
    w_frame_next = w_line_next && (w_sy_next == '0);
  end

  // Flags are decoded from the next coordinates so they align with sx/sy.
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      r_sx        <= c_h_last;
      r_sy        <= c_v_last;
      r_hsync     <= ~H_POL;
      r_vsync     <= ~V_POL;
      r_de        <= 1'b0;
      r_line      <= 1'b0;
      r_frame     <= 1'b0;
      r_frame_cnt <= 16'hFFFF;
    end else begin
      r_sx    <= w_sx_next;
      r_sy    <= w_sy_next;
      r_de    <= (w_sx_next < c_h_res) && (w_sy_next < c_v_res);
      r_hsync <= ((w_sx_next >= c_hs_sta) && (w_sx_next < c_hs_end)) ? H_POL : ~H_POL;
      r_vsync <= ((w_sy_next >= c_vs_sta) && (w_sy_next < c_vs_end)) ? V_POL : ~V_POL;
      r_line  <= w_line_next;
      r_frame <= w_frame_next;
      if (w_frame_next) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign sx        = r_sx;
  assign sy        = r_sy;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign de        = r_de;
  assign line      = r_line;
  assign frame     = r_frame;
  assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_display_timing_param.sv
// ============================================================================
// Module   : tb_display_timing_param
// Brief    : Directed bench for display_timing_param (default and small modes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_timing_param;

  typedef struct {
    int sx;
    int sy;
    int hs;
    int vs;
    int de;
    int ln;
    int fr;
    int fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  logic [9:0]  sx0, sy0;
  logic        hs0, vs0, de0, ln0, fr0;
  logic [15:0] fc0;
  logic [5:0]  sx1, sy1;
  logic        hs1, vs1, de1, ln1, fr1;
  logic [15:0] fc1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  longint edges0 = 0;
  longint edges1 = 0;
  exp_t x0, x1;

  always #5 clk = ~clk;

  display_timing_param u_dut0 (
    .clk_pix(clk), .rst_pix(rst0), .sx(sx0), .sy(sy0), .hsync(hs0), .vsync(vs0),
    .de(de0), .line(ln0), .frame(fr0), .frame_cnt(fc0)
  );

  display_timing_param #(
    .CORDW(6), .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(8), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut1 (
    .clk_pix(clk), .rst_pix(rst1), .sx(sx1), .sy(sy1), .hsync(hs1), .vsync(vs1),
    .de(de1), .line(ln1), .frame(fr1), .frame_cnt(fc1)
  );

  // Clock edges seen since reset was last asserted.
  always @(posedge clk or posedge rst0) edges0 <= rst0 ? 64'd0 : edges0 + 1;
  always @(posedge clk or posedge rst1) edges1 <= rst1 ? 64'd0 : edges1 + 1;

  // Pixel n (0-based, counted from the first edge after reset) sits at
  // sx = n mod H_TOTAL, sy = (n / H_TOTAL) mod V_TOTAL, in frame n / frame size.
  function automatic exp_t model(longint edges, int hres, int hfp, int hsw, int hbp,
                                 int vres, int vfp, int vsw, int vbp, int hpol, int vpol);
    exp_t e;
    longint n;
    int ht, vt;
    ht = hres + hfp + hsw + hbp;
    vt = vres + vfp + vsw + vbp;
    if (edges == 0) begin
      e.sx = ht - 1; e.sy = vt - 1; e.hs = 1 - hpol; e.vs = 1 - vpol;
      e.de = 0; e.ln = 0; e.fr = 0; e.fc = 65535;
    end else begin
      n = edges - 1;
      e.sx = int'(n % ht);
      e.sy = int'((n / ht) % vt);
      e.fc = int'((n / (ht * vt)) % 65536);
      e.de = (e.sx < hres && e.sy < vres) ? 1 : 0;
      e.hs = (e.sx >= hres + hfp && e.sx < hres + hfp + hsw) ? hpol : 1 - hpol;
      e.vs = (e.sy >= vres + vfp && e.sy < vres + vfp + vsw) ? vpol : 1 - vpol;
      e.ln = (e.sx == 0) ? 1 : 0;
      e.fr = (e.sx == 0 && e.sy == 0) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      x0 = model(edges0, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
      check("d0.sx", int'(sx0), x0.sx);
      check("d0.sy", int'(sy0), x0.sy);
      check("d0.hsync", int'(hs0), x0.hs);
      check("d0.vsync", int'(vs0), x0.vs);
      check("d0.de", int'(de0), x0.de);
      check("d0.line", int'(ln0), x0.ln);
      check("d0.frame", int'(fr0), x0.fr);
      check("d0.frame_cnt", int'(fc0), x0.fc);
      x1 = model(edges1, 16, 2, 3, 3, 8, 1, 1, 1, 1, 1);
      check("d1.sx", int'(sx1), x1.sx);
      check("d1.sy", int'(sy1), x1.sy);
      check("d1.hsync", int'(hs1), x1.hs);
      check("d1.vsync", int'(vs1), x1.vs);
      check("d1.de", int'(de1), x1.de);
      check("d1.line", int'(ln1), x1.ln);
      check("d1.frame", int'(fr1), x1.fr);
      check("d1.frame_cnt", int'(fc1), x1.fc);
    end
  end

  initial begin
    int de_fall, hs_fall, hs_rise, wrap_prev, wrap_sy, wrap_ln;
    int hs1_min, hs1_max, vs1_cnt, vs1_first_sy, vs1_first_sx, de1_cnt;
    int fr1_cnt, ln1_cnt, fr1_first, fr1_second;
    int prev_sx0, prev_de0, prev_hs0, waited;
    de_fall = -1; hs_fall = -1; hs_rise = -1; wrap_prev = -1; wrap_sy = -1; wrap_ln = -1;
    hs1_min = 99; hs1_max = -1; vs1_cnt = 0; vs1_first_sy = -1; vs1_first_sx = -1;
    de1_cnt = 0; fr1_cnt = 0; ln1_cnt = 0; fr1_first = -1; fr1_second = -1;

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst.sx", int'(sx0), 799);
    check("rst.sy", int'(sy0), 524);
    check("rst.de", int'(de0), 0);
    check("rst.hsync", int'(hs0), 1);
    check("rst.vsync", int'(vs0), 1);
    check("rst.frame", int'(fr0), 0);
    check("rst.frame_cnt", int'(fc0), 16'hFFFF);
    check("rst1.hsync", int'(hs1), 0);
    check("rst1.vsync", int'(vs1), 0);

    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);
    check("first.sx", int'(sx0), 0);
    check("first.sy", int'(sy0), 0);
    check("first.de", int'(de0), 1);
    check("first.line", int'(ln0), 1);
    check("first.frame", int'(fr0), 1);
    check("first.frame_cnt", int'(fc0), 0);

    prev_sx0 = int'(sx0); prev_de0 = int'(de0); prev_hs0 = int'(hs0);
    for (int k = 1; k <= 1700; k++) begin
      if (k > 1) @(negedge clk);
      if (k > 1 && sy0 == 10'd0) begin
        if (prev_de0 == 1 && de0 == 1'b0 && de_fall < 0) de_fall = int'(sx0);
        if (prev_hs0 == 1 && hs0 == 1'b0 && hs_fall < 0) hs_fall = int'(sx0);
        if (prev_hs0 == 0 && hs0 == 1'b1 && hs_rise < 0) hs_rise = int'(sx0);
      end
      if (k > 1 && sx0 == 10'd0 && wrap_prev < 0) begin
        wrap_prev = prev_sx0; wrap_sy = int'(sy0); wrap_ln = int'(ln0);
      end
      if (k <= 264) begin
        if (hs1) begin
          if (int'(sx1) < hs1_min) hs1_min = int'(sx1);
          if (int'(sx1) > hs1_max) hs1_max = int'(sx1);
        end
        if (vs1) begin
          vs1_cnt++;
          if (vs1_first_sy < 0) begin vs1_first_sy = int'(sy1); vs1_first_sx = int'(sx1); end
        end
        if (de1) de1_cnt++;
      end
      if (k <= 792) begin
        if (fr1) begin
          fr1_cnt++;
          if (fr1_first < 0) fr1_first = k;
          else if (fr1_second < 0) fr1_second = k;
        end
        if (ln1) ln1_cnt++;
      end
      if (k == 793) begin
        check("small.4th_frame_strobe", int'(fr1), 1);
        check("small.4th_frame_cnt", int'(fc1), 3);
      end
      prev_sx0 = int'(sx0); prev_de0 = int'(de0); prev_hs0 = int'(hs0);
    end

    check("h.de_fall_sx", de_fall, 640);
    check("h.hsync_fall_sx", hs_fall, 656);
    check("h.hsync_rise_sx", hs_rise, 752);
    check("h.wrap_from_sx", wrap_prev, 799);
    check("h.wrap_sy", wrap_sy, 1);
    check("h.wrap_line", wrap_ln, 1);
    check("small.hsync_first_sx", hs1_min, 18);
    check("small.hsync_last_sx", hs1_max, 20);
    check("small.vsync_cycles", vs1_cnt, 24);
    check("small.vsync_first_sy", vs1_first_sy, 9);
    check("small.vsync_first_sx", vs1_first_sx, 0);
    check("small.de_cycles", de1_cnt, 128);
    check("small.frame_strobes", fr1_cnt, 3);
    check("small.line_strobes", ln1_cnt, 33);
    check("small.frame_period", fr1_second - fr1_first, 264);

    // Mid-frame asynchronous reset of the default instance.
    waited = 0;
    while (!(sx0 == 10'd300) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("mid.reach_300_timeout", (waited < 1000) ? 1 : 0, 1);
    #2 rst0 = 1'b1;
    #1;
    check("mid.sx", int'(sx0), 799);
    check("mid.sy", int'(sy0), 524);
    check("mid.de", int'(de0), 0);
    check("mid.hsync", int'(hs0), 1);
    check("mid.vsync", int'(vs0), 1);
    check("mid.line", int'(ln0), 0);
    check("mid.frame", int'(fr0), 0);
    check("mid.frame_cnt", int'(fc0), 16'hFFFF);
    #1 rst0 = 1'b0;
    @(negedge clk);
    check("mid.after.sx", int'(sx0), 0);
    check("mid.after.sy", int'(sy0), 0);
    check("mid.after.frame", int'(fr0), 1);
    check("mid.after.frame_cnt", int'(fc0), 0);

    repeat (20) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
